fp_reduce_scheduler: RTL
========================

Name: fp_reduce_scheduler

Overview:
Sequential reduction controller that sums N_INPUTS streamed 32-bit IEEE-754 single-precision words using one shared, externally instantiated FP_Adder, instead of a full N-input adder tree.
- Pairs operands on the fly from three sources: the input stream, the adder's returning results, and a one-entry hold register.
- Issues at most one add per cycle and emits the final sum with a one-cycle valid pulse.
- Sits beside an FP_Adder instance in the Adder_NChannel area, as the low-area alternative to the Adder_64input/Adder_128input trees.

Parameters:
N_INPUTS, 128, number of words reduced per run (>=1)
CNT_W, $clog2(N_INPUTS+1), width of the receive, issue and in-flight counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
Start  in  1  begin a run; honoured only in IDLE
RMode  in  2  rounding mode, latched at Start, driven to the adder
Data_In  in  32  input operand
Valid_In  in  1  Data_In is valid; accepted when Valid_In && Ready_Out
Ready_Out  out  1  1 in ACCUM while fewer than N_INPUTS words have been received
Add_Data_A  out  32  adder operand A
Add_Data_B  out  32  adder operand B
Add_Valid_In  out  1  add issue strobe
Add_Mode  out  1  constant 0 (add)
Add_RMode  out  2  latched RMode
Add_Data_Out  in  32  adder result
Add_Valid_Out  in  1  adder result strobe
Data_Out  out  32  final sum; held until the next Start
Valid_Out  out  1  one-cycle pulse when the sum is available
Busy  out  1  1 when not in IDLE

Behaviour:
- Clock and reset: one clock domain; rst is synchronous and active-high and clears all state.
- Reset values: state=IDLE; Ready_Out, Add_Valid_In, Valid_Out, Busy = 0; Data_Out, Add_Data_A/B, hold register = 0; all counters = 0; Add_RMode = 0.
- IDLE -> ACCUM: on Start. Latches RMode and clears counters and hold.
- ACCUM, per cycle, the candidate operand set is:
  - R = Add_Data_Out, if Add_Valid_Out;
  - H = hold register, if hold_valid;
  - I = Data_In, if the input is accepted.
- Pairing rules, in priority order:
  - 2 or 3 candidates: issue one add. Pair order is (H,R), else (H,I), else (R,I). A leftover candidate is written to hold, and hold_valid is set.
  - Exactly 1 candidate: write it to hold.
  - None: no action.
- Hold overflow cannot occur: at most 3 candidates exist and each issue consumes 2. Ready_Out never deasserts because of operand pressure.
- Issue timing: Add_Data_A/B and Add_Valid_In are registered, so the adder sees the operands one cycle after pairing. Each issue increments issued_cnt and in_flight; each Add_Valid_Out decrements in_flight.
- Input accounting: recv_cnt increments on every accept. Ready_Out drops in the cycle after recv_cnt reaches N_INPUTS.
- Completion condition: recv_cnt==N_INPUTS, issued_cnt==N_INPUTS-1, in_flight==0, hold_valid, and no candidate present in the cycle. When true, the next cycle is DONE and Data_Out <= hold.
- N_INPUTS==1: no add is issued; the single word passes to Data_Out.
- DONE: Valid_Out=1 for exactly one cycle, then IDLE. Data_Out keeps its value.
- Start outside IDLE: ignored.
- Add_Valid_Out outside ACCUM: ignored and discarded. This covers stale results after a reset taken mid-run; the FP_Adder must share rst.
- Adder latency: arbitrary but in-order; the block relies only on the valid strobes.
- Latency bound: the result arrives no later than about ceil(log2 N)*(L_add+1) cycles after the last input accept, where L_add is the adder latency.
- Arithmetic: the block performs no arithmetic. All FP work, including rounding, specials and NaN, is done by FP_Adder. Summation order is deterministic for a given input timing.

Decomposition:
- Shared package fp_sched_pkg:
  - state enum {IDLE, ACCUM, DONE};
  - FP_W=32;
  - constants FP_ONE=32'h3F800000 and FP_ZERO=32'h0.
- Sub-module fp_pair_sel: combinational operand selector. Inputs are the R/H/I valids and data. Outputs are the issue flag, operands A/B, and the hold-write enable and data.
- Counters and the FSM stay in the top module.

Test Plan:
- N=4; adder model latency 3; inputs 3F800000, 40000000, 40400000, 40800000 on consecutive cycles -> exactly 3 adds issued; Data_Out=41200000 (10.0); single Valid_Out pulse.
- N=128; 128 × 3F800000 back-to-back; Ready_Out held at 1 throughout -> Data_Out=43000000 (128.0); issued_cnt=127.
- N=4; same data as the first scenario with random 0-5 cycle Valid_In gaps and adder latency 1 -> Data_Out=41200000; no lost or duplicated operand.
- N=1; Data_In=40490FDB -> no Add_Valid_In; Data_Out=40490FDB with Valid_Out pulse.
- rst asserted after 50 of 128 inputs while adds are in flight -> all outputs return to reset values next cycle. Late Add_Valid_Out is ignored. A fresh run of 128 × 3F800000 then gives 43000000.
- Start pulsed in ACCUM and in DONE -> no effect; RMode=2'b01 latched at the first Start appears on Add_RMode for the whole run.

Source files
------------

// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the sequential FP reduction scheduler.
package fp_sched_pkg;

    localparam int FP_W = 32;

    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/fp_pair_sel.sv
// Combinational operand pairing among adder result (R), hold register (H)
// and accepted input (I); at most one add per cycle, a leftover goes to hold.
module fp_pair_sel
    import fp_sched_pkg::*;
(
    input  logic            r_valid,
    input  logic [FP_W-1:0] r_data,
    input  logic            h_valid,
    input  logic [FP_W-1:0] h_data,
    input  logic            i_valid,
    input  logic [FP_W-1:0] i_data,
    output logic            issue,
    output logic [FP_W-1:0] op_a,
    output logic [FP_W-1:0] op_b,
    output logic            hold_we,
    output logic [FP_W-1:0] hold_data
);

    always_comb begin
        issue     = 1'b0;
        op_a      = FP_ZERO;
        op_b      = FP_ZERO;
        hold_we   = 1'b0;
        hold_data = FP_ZERO;
        if (h_valid && r_valid) begin
            issue = 1'b1;
            op_a  = h_data;
            op_b  = r_data;
            // Only the input can be left over when all three are present.
            if (i_valid) begin
                hold_we   = 1'b1;
                hold_data = i_data;
            end
        end else if (h_valid && i_valid) begin
            issue = 1'b1;
            op_a  = h_data;
            op_b  = i_data;
        end else if (r_valid && i_valid) begin
            issue = 1'b1;
            op_a  = r_data;
            op_b  = i_data;
        end else if (h_valid) begin
            hold_we   = 1'b1;
            hold_data = h_data;
        end else if (r_valid) begin
            hold_we   = 1'b1;
            hold_data = r_data;
        end else if (i_valid) begin
            hold_we   = 1'b1;
            hold_data = i_data;
        end
    end

endmodule

// File: rtl/fp_reduce_scheduler.sv
// Sums N_INPUTS streamed FP32 words through one shared external FP adder.
//   state | meaning
//   IDLE  | waiting for Start; outputs from the last run are held
//   ACCUM | accepting inputs, pairing operands, tracking adds in flight
//   DONE  | final sum on Data_Out, Valid_Out pulses for this one cycle
module fp_reduce_scheduler
    import fp_sched_pkg::*;
#(
    parameter int N_INPUTS = 128,
    parameter int CNT_W    = $clog2(N_INPUTS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Start,
    input  logic [1:0]      RMode,
    input  logic [FP_W-1:0] Data_In,
    input  logic            Valid_In,
    output logic            Ready_Out,
    output logic [FP_W-1:0] Add_Data_A,
    output logic [FP_W-1:0] Add_Data_B,
    output logic            Add_Valid_In,
    output logic            Add_Mode,
    output logic [1:0]      Add_RMode,
    input  logic [FP_W-1:0] Add_Data_Out,
    input  logic            Add_Valid_Out,
    output logic [FP_W-1:0] Data_Out,
    output logic            Valid_Out,
    output logic            Busy
);

    localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_INPUTS);
    localparam logic [CNT_W-1:0] LAST_ADD = CNT_W'(N_INPUTS - 1);

    state_e            state_q, state_d;
    logic [1:0]        rmode_q, rmode_d;
    logic [CNT_W-1:0]  recv_q, recv_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [FP_W-1:0]   hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [FP_W-1:0]   add_a_q, add_a_d;
    logic [FP_W-1:0]   add_b_q, add_b_d;
    logic              add_valid_q, add_valid_d;
    logic [FP_W-1:0]   data_out_q, data_out_d;

    logic              in_accum;
    logic              ready;
    logic              accept;
    logic              r_valid;
    logic              h_valid;
    logic              done_cond;
    logic              issue;
    logic [FP_W-1:0]   op_a;
    logic [FP_W-1:0]   op_b;
    logic              hold_we;
    logic [FP_W-1:0]   hold_wdata;

    // Results arriving outside ACCUM (e.g. stale after reset) are dropped here.
    always_comb begin
        in_accum = (state_q == ACCUM);
        ready    = in_accum && (recv_q < N_CNT);
        accept   = Valid_In && ready;
        r_valid  = in_accum && Add_Valid_Out;
        h_valid  = in_accum && hold_valid_q;
    end

    fp_pair_sel u_pair_sel (
        .r_valid   (r_valid),
        .r_data    (Add_Data_Out),
        .h_valid   (h_valid),
        .h_data    (hold_q),
        .i_valid   (accept),
        .i_data    (Data_In),
        .issue     (issue),
        .op_a      (op_a),
        .op_b      (op_b),
        .hold_we   (hold_we),
        .hold_data (hold_wdata)
    );

    always_comb begin
        done_cond = in_accum && (recv_q == N_CNT) && (issued_q == LAST_ADD) &&
                    (inflight_q == '0) && hold_valid_q && !r_valid && !accept;

        state_d      = state_q;
        rmode_d      = rmode_q;
        recv_d       = recv_q;
        issued_d     = issued_q;
        inflight_d   = inflight_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_valid_d  = 1'b0;
        data_out_d   = data_out_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d      = ACCUM;
                    rmode_d      = RMode;
                    recv_d       = '0;
                    issued_d     = '0;
                    inflight_d   = '0;
                    hold_d       = FP_ZERO;
                    hold_valid_d = 1'b0;
                end
            end
            ACCUM: begin
                if (done_cond) begin
                    state_d    = DONE;
                    data_out_d = hold_q;
                end else begin
                    recv_d     = recv_q + CNT_W'(accept);
                    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(r_valid);
                    if (issue) begin
                        add_a_d     = op_a;
                        add_b_d     = op_b;
                        add_valid_d = 1'b1;
                        issued_d    = issued_q + CNT_W'(1);
                    end
                    // An issue always consumes the hold entry if one was present.
                    if (hold_we) begin
                        hold_d       = hold_wdata;
                        hold_valid_d = 1'b1;
                    end else if (issue) begin
                        hold_valid_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rmode_q      <= 2'b00;
            recv_q       <= '0;
            issued_q     <= '0;
            inflight_q   <= '0;
            hold_q       <= FP_ZERO;
            hold_valid_q <= 1'b0;
            add_a_q      <= FP_ZERO;
            add_b_q      <= FP_ZERO;
            add_valid_q  <= 1'b0;
            data_out_q   <= FP_ZERO;
        end else begin
            state_q      <= state_d;
            rmode_q      <= rmode_d;
            recv_q       <= recv_d;
            issued_q     <= issued_d;
            inflight_q   <= inflight_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_valid_q  <= add_valid_d;
            data_out_q   <= data_out_d;
        end
    end

    assign Ready_Out    = ready;
    assign Add_Data_A   = add_a_q;
    assign Add_Data_B   = add_b_q;
    assign Add_Valid_In = add_valid_q;
    assign Add_Mode     = 1'b0;
    assign Add_RMode    = rmode_q;
    assign Data_Out     = data_out_q;
    assign Valid_Out    = (state_q == DONE);
    assign Busy         = (state_q != IDLE);

endmodule
